// File: rtl/spi_bus_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : dso_spi_pkg                                                |
// | Description : Shared definitions for the DSO SPI bus arbiter:            |
// |               slave-select codes, requester indices, arbiter state enum  |
// |               and the modulo-3 round-robin step helper.                  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package dso_spi_pkg;

  // Slave-select codes understood by the SPI master
  localparam logic [2:0] SS_NONE = 3'b000;
  localparam logic [2:0] SS_CH1  = 3'b001;
  localparam logic [2:0] SS_CH2  = 3'b010;
  localparam logic [2:0] SS_CH3  = 3'b011;
  localparam logic [2:0] SS_EEP  = 3'b100;
  localparam logic [2:0] SS_TRIG = 3'b111;

  // Requester indices
  localparam logic [1:0] REQ_CMD  = 2'd0;
  localparam logic [1:0] REQ_CAL  = 2'd1;
  localparam logic [1:0] REQ_TRIG = 2'd2;

  localparam int unsigned NUM_REQ = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_BUSY   = 2'd2,
    ST_HOLD   = 2'd3
  } arb_state_t;

  // Next requester index in rotation 0 -> 1 -> 2 -> 0
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx >= REQ_TRIG) ? REQ_CMD : idx + 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_bus_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface   : spi_bus_arbiter_if                                         |
// | Description : Requester-side and SPI-master-side signals of the arbiter. |
// |   req/req_lock/req_data/req_ss : requester requests (3 requesters)       |
// |   gnt/done/err/rd_data         : per-requester grant and completion      |
// |   wrt_SPI/SPI_data/ss          : launch towards the SPI master           |
// |   SPI_done/SPI_rd_data         : completion from the SPI master          |
// |   modport slave  : the arbiter's view                                    |
// |   modport master : the requesters' and SPI master's view                 |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface spi_bus_arbiter_if;
  import dso_spi_pkg::*;

  logic [NUM_REQ-1:0]      req;
  logic [NUM_REQ-1:0]      req_lock;
  logic [16*NUM_REQ-1:0]   req_data;
  logic [3*NUM_REQ-1:0]    req_ss;
  logic [NUM_REQ-1:0]      gnt;
  logic [NUM_REQ-1:0]      done;
  logic [NUM_REQ-1:0]      err;
  logic [15:0]             rd_data;
  logic                    wrt_SPI;
  logic [15:0]             SPI_data;
  logic [2:0]              ss;
  logic                    SPI_done;
  logic [15:0]             SPI_rd_data;

  modport slave (
    input  req, req_lock, req_data, req_ss, SPI_done, SPI_rd_data,
    output gnt, done, err, rd_data, wrt_SPI, SPI_data, ss
  );

  modport master (
    output req, req_lock, req_data, req_ss, SPI_done, SPI_rd_data,
    input  gnt, done, err, rd_data, wrt_SPI, SPI_data, ss
  );

endinterface
`default_nettype wire

// File: rtl/spi_bus_arbiter_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rr_pick                                                    |
// | Description : Combinational round-robin picker over three requesters.    |
// |               Search starts at i_ptr+1 and wraps.                        |
// |   i_req[2:0] : request vector                                            |
// |   i_ptr[1:0] : index of the last owner                                   |
// |   o_gnt[2:0] : one-hot winner (0 when no request)                        |
// |   o_idx[1:0] : winner index (don't-care when no request)                 |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module rr_pick
  import dso_spi_pkg::*;
(
  input  wire logic [2:0] i_req,
  input  wire logic [1:0] i_ptr,
  output logic      [2:0] o_gnt,
  output logic      [1:0] o_idx
);

  logic [1:0] w_c0;
  logic [1:0] w_c1;
  logic [1:0] w_c2;
  logic [3:0] w_req_pad;
  logic [3:0] w_onehot;

  // Padding to four entries keeps every 2-bit index in range
  assign w_req_pad = {1'b0, i_req};
  assign w_c0      = rr_next(i_ptr);
  assign w_c1      = rr_next(w_c0);
  assign w_c2      = rr_next(w_c1);

  always_comb begin
    o_idx = w_c0;
    if (w_req_pad[w_c0])      o_idx = w_c0;
    else if (w_req_pad[w_c1]) o_idx = w_c1;
    else if (w_req_pad[w_c2]) o_idx = w_c2;
  end

  assign w_onehot = 4'b0001 << o_idx;
  assign o_gnt    = (|i_req) ? w_onehot[2:0] : 3'b000;

endmodule
`default_nettype wire

// File: rtl/spi_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : spi_bus_arbiter                                            |
// | Description : Shares one SPI master between the command processor,       |
// |               calibration loader and trigger auto-level engine.          |
// |               Round-robin grant, one wrt_SPI pulse per transaction,      |
// |               optional bus lock across back-to-back transactions and a   |
// |               watchdog that aborts a transaction the master never ends.  |
// |   clk   : clock                                                          |
// |   rst_n : asynchronous active-low reset                                  |
// |   bus   : spi_bus_arbiter_if.slave (requester and SPI master signals)    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module spi_bus_arbiter
  import dso_spi_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
)
(
  input  wire logic         clk,
  input  wire logic         rst_n,
  spi_bus_arbiter_if.slave  bus
);

  localparam int unsigned    CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  arb_state_t    r_state;
  logic [2:0]    r_gnt;
  logic [1:0]    r_own;
  logic [1:0]    r_ptr;
  logic [15:0]   r_data;
  logic [2:0]    r_ss;
  logic          r_wrt;
  logic [CW-1:0] r_cnt;

  logic [2:0]    w_pick_gnt;
  logic [1:0]    w_pick_idx;
  logic [1:0]    w_sel_idx;
  logic [15:0]   w_sel_data;
  logic [2:0]    w_sel_ss;
  logic          w_sel_req;
  logic          w_sel_lock;
  logic          w_busy;
  logic          w_cnt_last;

  rr_pick u_rr_pick (
    .i_req (bus.req),
    .i_ptr (r_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx)
  );

  // In IDLE the candidate is the round-robin winner; otherwise the owner
  assign w_sel_idx = (r_state == ST_IDLE) ? w_pick_idx : r_own;

  always_comb begin
    w_sel_data = bus.req_data[15:0];
    w_sel_ss   = bus.req_ss[2:0];
    w_sel_req  = bus.req[0];
    w_sel_lock = bus.req_lock[0];
    case (w_sel_idx)
      REQ_CAL: begin
        w_sel_data = bus.req_data[31:16];
        w_sel_ss   = bus.req_ss[5:3];
        w_sel_req  = bus.req[1];
        w_sel_lock = bus.req_lock[1];
      end
      REQ_TRIG: begin
        w_sel_data = bus.req_data[47:32];
        w_sel_ss   = bus.req_ss[8:6];
        w_sel_req  = bus.req[2];
        w_sel_lock = bus.req_lock[2];
      end
      default: ;
    endcase
  end

  assign w_busy     = (r_state == ST_BUSY);
  assign w_cnt_last = w_busy && (r_cnt == CNT_LAST);

  // Completion strobes are combinational so the owner sees them in the
  // SPI_done cycle; done takes precedence over a coincident watchdog expiry.
  assign bus.done    = (w_busy && bus.SPI_done) ? r_gnt : 3'b000;
  assign bus.err     = (w_cnt_last && !bus.SPI_done) ? r_gnt : 3'b000;
  assign bus.rd_data = (w_busy && bus.SPI_done) ? bus.SPI_rd_data : 16'h0000;

  assign bus.gnt      = r_gnt;
  assign bus.wrt_SPI  = r_wrt;
  assign bus.SPI_data = r_data;
  assign bus.ss       = r_ss;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_gnt   <= 3'b000;
      r_own   <= REQ_CMD;
      r_ptr   <= REQ_TRIG;
      r_data  <= 16'h0000;
      r_ss    <= SS_NONE;
      r_wrt   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_wrt <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (|w_pick_gnt) begin
            r_gnt   <= w_pick_gnt;
            r_own   <= w_pick_idx;
            r_data  <= w_sel_data;
            r_ss    <= w_sel_ss;
            r_wrt   <= 1'b1;
            r_state <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          r_cnt   <= '0;
          r_state <= ST_BUSY;
        end
        ST_BUSY: begin
          r_cnt <= r_cnt + 1'b1;
          if (bus.SPI_done && w_sel_lock) begin
            r_state <= ST_HOLD;
          end else if (bus.SPI_done || w_cnt_last) begin
            r_ptr   <= r_own;
            r_gnt   <= 3'b000;
            r_ss    <= SS_NONE;
            r_state <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          // Other requesters are ignored while the owner keeps the lock
          if (w_sel_req) begin
            r_data  <= w_sel_data;
            r_ss    <= w_sel_ss;
            r_wrt   <= 1'b1;
            r_state <= ST_LAUNCH;
          end else if (!w_sel_lock) begin
            r_ptr   <= r_own;
            r_gnt   <= 3'b000;
            r_ss    <= SS_NONE;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/spi_bus_arbiter.md
# spi_bus_arbiter

Arbitrates the DSO's single SPI master among three requesters: command processor (index 0), boot-time calibration loader (index 1) and trigger auto-level engine (index 2). It captures the winner's 16-bit word and slave-select code, issues one `wrt_SPI` pulse, and holds the grant until `SPI_done`. It returns completion and read data to the owner. A lock input lets a requester keep the bus across back-to-back transactions, such as a two-phase EEPROM read, and a watchdog releases the bus if the master never completes.

## Interface
- TIMEOUT, 1024: cycles in BUSY without `SPI_done` before abort; must be ≥2.
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req  in  3  per-requester transaction request (level; held until own done/err)
- req_lock  in  3  per-requester bus hold after completion
- req_data  in  48  packed 16-bit SPI words; requester i at [16i+15:16i]
- req_ss  in  9  packed 3-bit ss codes; requester i at [3i+2:3i]
- gnt  out  3  one-hot current owner; 0 when unowned
- done  out  3  one-cycle completion strobe to owner
- err  out  3  one-cycle timeout strobe to owner
- rd_data  out  16  SPI read word; valid when any done bit is high
- wrt_SPI  out  1  one-cycle start pulse to SPI master
- SPI_data  out  16  registered word to SPI master
- ss  out  3  registered slave-select code to SPI master
- SPI_done  in  1  master completion
- SPI_rd_data  in  16  master received word

## Operation
- States:
  - IDLE, LAUNCH, BUSY and HOLD.
  - State, gnt, SPI_data, ss, wrt_SPI, rr pointer and timeout counter are registered.
  - done, err and rd_data are combinational.
- IDLE:
  - If any req is high, pick a winner round-robin starting from pointer+1.
  - At the next edge, load gnt, SPI_data and ss from the winner, set wrt_SPI=1 and go to LAUNCH.
- LAUNCH: wrt_SPI is high this cycle only. Next state is BUSY, with the counter cleared.
- BUSY: ss and SPI_data are held, and the counter increments.
  - On SPI_done: done[owner]=1 and rd_data=SPI_rd_data in the same cycle.
    - If req_lock[owner] is high, next state is HOLD.
    - Otherwise the pointer is set to the owner, gnt is cleared, ss is set to 000 and next state is IDLE.
  - When the counter reaches TIMEOUT-1 without SPI_done: err[owner]=1, release exactly as for an unlocked done, and go to IDLE.
  - If SPI_done and the timeout occur in the same cycle, done wins and err stays 0.
- HOLD: gnt and ss are held, and other requesters are ignored.
  - If req[owner] is high: load a new word and ss from the owner, set wrt_SPI=1 and go to LAUNCH.
  - Else if req_lock[owner] is low: release to IDLE and update the pointer.
  - If req and lock are both high, relaunch has priority.
- Requester contract:
  - A requester drops req on the edge at which it samples done or err.
  - The arbiter never samples req in the cycle done/err is high, so no double grant occurs.
- ss code 000 means no slave; it is driven whenever gnt==0.

## Timing
- Reset values:
  - State IDLE, gnt 0, wrt_SPI 0, SPI_data 0000, ss 000, counter 0.
  - Pointer 2, so requester 0 wins first.
  - done, err and rd_data are 0 because they are gated by state and gnt.
- req rising in IDLE in cycle n gives wrt_SPI and gnt high in cycle n+1, and BUSY in cycle n+2.
- SPI_done in cycle k gives done in cycle k; IDLE or HOLD in cycle k+1; and the earliest next wrt_SPI in cycle k+2.
- Locked relaunch: req seen in HOLD in cycle m gives wrt_SPI in cycle m+1.
- A timeout with no SPI_done gives err in the TIMEOUT-th BUSY cycle.
- Reset mid-transaction returns the block to IDLE immediately, with no done or err. The SPI master shares rst_n.
- Round-robin fairness: with all three requesting continuously, unlocked grants rotate 0→1→2→0.

## Structure
- Package dso_spi_pkg holds:
  - ss codes: SS_NONE 000, SS_CH1 001, SS_CH2 010, SS_CH3 011, SS_EEP 100, SS_TRIG 111.
  - Requester indices: REQ_CMD 0, REQ_CAL 1, REQ_TRIG 2.
  - The state enum.
- One sub-module, rr_pick: combinational round-robin picker taking req[2:0] and ptr[1:0] and returning a one-hot winner plus an index.

## Test plan
- After reset, req=001 with word 1328 and ss 001 → wrt_SPI in cycle 1 with SPI_data 1328, ss 001, gnt 001; SPI_done after 16 cycles → done=001; then ss=000.
- req=111 held throughout, with each requester dropping req on done and re-raising it 2 cycles later → grant order 0,1,2,0,1,2.
- Requester 1 with lock=1 sends word 0A00 with ss 100; done; HOLD with gnt 010 and ss 100 while req 0 is pending; then word 0000 relaunches, done returns rd_data from SPI_rd_data, lock drops, and req 0 is granted next.
- No SPI_done with TIMEOUT=8 → err=owner in BUSY cycle 8, gnt 0, and the next requester is granted.
- SPI_done coincident with the timeout cycle → done=1, err=0.
- rst_n asserted during BUSY → all outputs are at reset values asynchronously; after release, a pending req is re-granted with wrt_SPI one cycle later.
